// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS lb/lh/lw/lbu/lhu/sb/sh/sw bus unit; define LSU_MISALIGN_CHECK_EN to trap misaligned accesses
module load_store_unit #(
    parameter int OPCODE_WIDTH = 6,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [DATA_WIDTH-1:0]   store_data,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    exc_misalign,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [OPCODE_WIDTH-1:0] OP_LB  = OPCODE_WIDTH'(6'h20);
    localparam logic [OPCODE_WIDTH-1:0] OP_LH  = OPCODE_WIDTH'(6'h21);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = OPCODE_WIDTH'(6'h23);
    localparam logic [OPCODE_WIDTH-1:0] OP_LBU = OPCODE_WIDTH'(6'h24);
    localparam logic [OPCODE_WIDTH-1:0] OP_LHU = OPCODE_WIDTH'(6'h25);
    localparam logic [OPCODE_WIDTH-1:0] OP_SB  = OPCODE_WIDTH'(6'h28);
    localparam logic [OPCODE_WIDTH-1:0] OP_SH  = OPCODE_WIDTH'(6'h29);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW  = OPCODE_WIDTH'(6'h2B);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    // size: 0 byte, 1 halfword, 2 word
    typedef struct packed {
        logic       ok;
        logic       store;
        logic       sgn;
        logic [1:0] size;
    } dec_t;

    function automatic dec_t decode(input logic [OPCODE_WIDTH-1:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_LB:   d = {1'b1, 1'b0, 1'b1, 2'd0};
            OP_LH:   d = {1'b1, 1'b0, 1'b1, 2'd1};
            OP_LW:   d = {1'b1, 1'b0, 1'b0, 2'd2};
            OP_LBU:  d = {1'b1, 1'b0, 1'b0, 2'd0};
            OP_LHU:  d = {1'b1, 1'b0, 1'b0, 2'd1};
            OP_SB:   d = {1'b1, 1'b1, 1'b0, 2'd0};
            OP_SH:   d = {1'b1, 1'b1, 1'b0, 2'd1};
            OP_SW:   d = {1'b1, 1'b1, 1'b0, 2'd2};
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t                  state, state_nxt;
    dec_t                    req_dec, cur_dec;
    logic [OPCODE_WIDTH-1:0] op_r;
    logic [DATA_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   sdata_r;
    logic [DATA_WIDTH-1:0]   load_data_r;
    logic                    exc_r;
    logic                    accept;
    logic                    reject;
    logic [DATA_WIDTH-1:0]   aligned_addr;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [DATA_WIDTH-1:0]   load_fmt;

    assign req_dec = decode(op_code);
    assign cur_dec = decode(op_r);
    assign accept  = (state == IDLE) && req_valid && req_dec.ok;

`ifdef LSU_MISALIGN_CHECK_EN
    assign reject = ((req_dec.size == 2'd1) && alu_result[0]) ||
                    ((req_dec.size == 2'd2) && (alu_result[1:0] != 2'b00));
`else
    assign reject = 1'b0;
`endif

    // Accesses that reach the bus are forced to natural alignment.
    always_comb begin
        aligned_addr = alu_result;
        case (req_dec.size)
            2'd1:    aligned_addr = {alu_result[DATA_WIDTH-1:1], 1'b0};
            2'd2:    aligned_addr = {alu_result[DATA_WIDTH-1:2], 2'b00};
            default: aligned_addr = alu_result;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = reject ? DONE : BUS;
            BUS:     if (mem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == DONE);
        mem_req    = (state == BUS);
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = '0;
        if (state == BUS) begin
            mem_we   = cur_dec.store;
            mem_addr = {addr_r[DATA_WIDTH-1:2], 2'b00};
            if (!cur_dec.store || cur_dec.size == 2'd2)
                mem_be = 4'b1111;
            else if (cur_dec.size == 2'd0)
                mem_be = 4'b0001 << addr_r[1:0];
            else
                mem_be = addr_r[1] ? 4'b1100 : 4'b0011;
            if (cur_dec.store) begin
                case (cur_dec.size)
                    2'd0:    mem_wdata = {4{sdata_r[7:0]}};
                    2'd1:    mem_wdata = {2{sdata_r[15:0]}};
                    default: mem_wdata = sdata_r;
                endcase
            end
        end
    end

    always_comb begin
        rd_byte  = 8'h00;
        case (addr_r[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half  = addr_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_fmt = mem_rdata;
        case (cur_dec.size)
            2'd0:    load_fmt = {{24{cur_dec.sgn & rd_byte[7]}}, rd_byte};
            2'd1:    load_fmt = {{16{cur_dec.sgn & rd_half[15]}}, rd_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_r        <= '0;
            addr_r      <= '0;
            sdata_r     <= '0;
            load_data_r <= '0;
            exc_r       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r    <= op_code;
                addr_r  <= aligned_addr;
                sdata_r <= store_data;
                if (reject) begin
                    load_data_r <= '0;
                    exc_r       <= 1'b1;
                end
            end
            if (state == BUS && mem_ack) begin
                load_data_r <= cur_dec.store ? '0 : load_fmt;
                exc_r       <= 1'b0;
            end
        end
    end

    assign load_data    = load_data_r;
    assign exc_misalign = exc_r;

endmodule
